// File: rtl/inst_fetch.sv
// Instruction fetch: assembles a 32-bit little-endian word from a byte-wide memory
// port, one byte per free cycle, with flush/stall handling toward the IF/ID stage.
//
//  state | meaning
//  IDLE  | latch base address, clear counters and byte buffers
//  FETCH | issue bytes 0..3 when the memory port is not busy
//  LAST  | capture byte 3, publish instruction
//  DONE  | instruction valid; hold while stall_i, else consumed
module inst_fetch #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              mem_busy_i,
    input  logic [7:0]        mem_data_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_issue_cnt;
    logic              r_pend;
    logic [1:0]        r_cap_idx;
    logic [3:0][7:0]   r_buf;
    logic              w_issue;

    assign w_issue    = (r_state == S_FETCH) && !mem_busy_i && !flush_i && !rst;
    assign mem_rd_o   = w_issue;
    assign mem_addr_o = r_base + ADDR_W'(r_issue_cnt);
    assign stallreq_o = rst || (r_state != S_DONE);

    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_FETCH;
                S_FETCH: if (!mem_busy_i && r_issue_cnt == 2'd3) w_next = S_LAST;
                S_LAST:  w_next = S_DONE;
                S_DONE:  if (!stall_i) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_issue_cnt  <= '0;
            r_pend       <= 1'b0;
            r_cap_idx    <= '0;
            r_buf        <= '0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            r_state <= w_next;
            if (flush_i) begin
                r_pend       <= 1'b0;
                inst_valid_o <= 1'b0;
            end else begin
                // data for a byte issued last cycle is on the bus now, busy or not
                if (r_pend) r_buf[r_cap_idx] <= mem_data_i;
                r_pend    <= w_issue;
                r_cap_idx <= r_issue_cnt;
                case (r_state)
                    S_IDLE: begin
                        r_base      <= pc_i;
                        r_issue_cnt <= '0;
                        r_buf       <= '0;
                    end
                    S_FETCH: if (w_issue) r_issue_cnt <= r_issue_cnt + 2'd1;
                    S_LAST: begin
                        inst_o       <= {mem_data_i, r_buf[2], r_buf[1], r_buf[0]};
                        inst_pc_o    <= r_base;
                        inst_valid_o <= 1'b1;
                    end
                    S_DONE: if (!stall_i) inst_valid_o <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the instruction address width.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 SHALL have port pc_i, input, ADDR_W bits, the fetch address from the PC register; stable at posedge.
REQ-005 SHALL have port flush_i, input, 1 bit, a taken branch or jump from ID or EX; abort the current fetch.
REQ-006 SHALL have port stall_i, input, 1 bit, a downstream (IF/ID) stall; hold the completed instruction.
REQ-007 SHALL have port mem_busy_i, input, 1 bit, the byte-wide memory port is granted to the data side this cycle.
REQ-008 SHALL have port mem_data_i, input, 8 bits, read data for the address issued in the previous cycle.
REQ-009 SHALL have port mem_rd_o, output, 1 bit, the read strobe, combinational from state.
REQ-010 SHALL have port mem_addr_o, output, ADDR_W bits, the byte address, combinational from state.
REQ-011 SHALL have port inst_o, output, 32 bits, the assembled instruction, registered.
REQ-012 SHALL have port inst_pc_o, output, ADDR_W bits, the address of inst_o, registered.
REQ-013 SHALL have port inst_valid_o, output, 1 bit, inst_o is valid.
REQ-014 SHALL have port stallreq_o, output, 1 bit, the fetch is incomplete; feeds stall[0] generation.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LAST and DONE.
REQ-016 In IDLE, SHALL latch base<=pc_i, clear issue and capture counters and byte buffers, and go to FETCH; mem_rd_o is 0.
REQ-017 In FETCH with mem_busy_i=0, SHALL drive mem_rd_o=1 and mem_addr_o=base+issue_cnt, then increment issue_cnt (2 bits).
REQ-018 In FETCH with mem_busy_i=1, SHALL drive mem_rd_o=0 and keep issue_cnt unchanged.
REQ-019 SHALL go from FETCH to LAST after byte 3 is issued.
REQ-020 SHALL record a pending flag for every issued byte and capture mem_data_i in the next cycle regardless of mem_busy_i.
REQ-021 SHALL assemble bytes little-endian: byte k goes to inst bits [8k+7:8k].
REQ-022 In LAST, SHALL capture byte 3, load inst_o and inst_pc_o<=base, set inst_valid_o=1, and go to DONE.
REQ-023 SHALL set stallreq_o=1 in IDLE, FETCH and LAST, and 0 in DONE.
REQ-024 In DONE with stall_i=1, SHALL hold inst_o, inst_pc_o and inst_valid_o unchanged.
REQ-025 In DONE with stall_i=0, SHALL treat the instruction as consumed at that posedge, clear inst_valid_o, and go to IDLE.
REQ-026 On flush_i=1 in any state, SHALL go to IDLE next cycle, clear inst_valid_o, drop pending captures, and drive mem_rd_o=0 that cycle.
REQ-027 flush_i SHALL take priority over stall_i, mem_busy_i and completion in the same cycle.
REQ-028 With no memory contention, SHALL take exactly 6 cycles from IDLE entry to the first cycle of inst_valid_o=1.
REQ-029 SHALL stretch that latency by one cycle per mem_busy_i cycle in FETCH.
REQ-030 SHALL form mem_addr_o as base+issue_cnt truncated to ADDR_W, wrapping from 0xFFFFFFFF to 0x0.
REQ-031 SHALL not check or trap on misaligned pc_i.

Reset
REQ-032 With rst=1 at posedge, SHALL go to IDLE and set inst_o=0, inst_pc_o=0, inst_valid_o=0, base=0, counters=0 and pending=0.
REQ-033 During reset, SHALL drive mem_rd_o=0 and stallreq_o=1.
REQ-034 Reset SHALL override flush_i and stall_i.
REQ-035 A reset during FETCH SHALL discard all partial bytes.
REQ-036 The first fetch after reset SHALL sample pc_i in the first cycle with rst=0.

Verification
REQ-037 Basic fetch: pc_i=0x10, memory bytes 0x13,0x05,0x10,0x00 at 0x10-0x13, no busy -> addresses 0x10..0x13 issued on cycles 1-4; inst_o=0x00100513, inst_pc_o=0x10, inst_valid_o=1 at cycle 6; stallreq_o=0 only in DONE.
REQ-038 Contention: mem_busy_i=1 for 2 cycles after byte 1 is issued -> byte 1 still captured; no address repeated or skipped; inst_valid_o at cycle 8 with the correct word.
REQ-039 Downstream stall: stall_i=1 for 3 cycles in DONE -> inst_o is held; on stall_i=0 the next cycle is IDLE latching the new pc_i=0x14.
REQ-040 Flush mid-fetch: flush_i=1 after 2 bytes issued, pc_i=0x100 -> mem_rd_o=0 that cycle; new fetch issues 0x100..0x103; no stale bytes appear in inst_o.
REQ-041 Wrap: pc_i=0xFFFFFFFE -> issued addresses are 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-042 Reset in FETCH: rst=1 during byte 2 -> all outputs 0 next cycle; a clean fetch from pc_i follows after reset is released.
